// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap mode and saturating counter.
// Optional don't-care mask port/register enabled by SEQDET_MASK_EN.
module seq_detector_param #(
  parameter int          PATTERN_W   = 4,
  parameter logic [31:0] PATTERN_RST = 32'b0111,
  parameter int          CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 overlap,
  input  logic                 pat_load,
  input  logic [PATTERN_W-1:0] pat_in,
`ifdef SEQDET_MASK_EN
  input  logic [PATTERN_W-1:0] pat_mask,
`endif
  input  logic                 clr_count,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
  output logic [PATTERN_W-1:0] hist,
  output logic                 armed
);

  localparam int FW = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [PATTERN_W-1:0] r_hist;
  logic [PATTERN_W-1:0] r_pat;
  logic [FW-1:0]        r_fill;
  logic                 r_match;
  logic                 r_armed;
  logic [CNT_W-1:0]     r_cnt;

  logic [PATTERN_W-1:0] w_new_hist;
  logic [FW-1:0]        w_fill_inc;
  logic [FW-1:0]        w_fill_d;
  logic [CNT_W-1:0]     w_cnt_d;
  logic                 w_cmp;
  logic                 w_hit;

`ifdef SEQDET_MASK_EN
  logic [PATTERN_W-1:0] r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (pat_load) begin
      r_mask <= pat_mask;
    end
  end

  assign w_cmp = ((w_new_hist | r_mask) == (r_pat | r_mask));
`else
  assign w_cmp = (w_new_hist == r_pat);
`endif

  assign w_new_hist = {r_hist[PATTERN_W-2:0], din};
  assign w_fill_inc = (r_fill == FULL) ? r_fill : r_fill + 1'b1;
  assign w_hit = din_valid & ~pat_load & (w_fill_inc == FULL) & w_cmp;

  always_comb begin
    w_fill_d = r_fill;
    unique case (1'b1)
      pat_load:           w_fill_d = '0;
      din_valid:          w_fill_d = (w_hit & ~overlap) ? '0 : w_fill_inc;
      default:            w_fill_d = r_fill;
    endcase
  end

  // Clear takes effect first, so a coincident hit leaves a count of one.
  always_comb begin
    w_cnt_d = r_cnt;
    if (clr_count) begin
      w_cnt_d = CNT_W'(w_hit);
    end else if (w_hit && (r_cnt != CMAX)) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_pat   <= PATTERN_RST[PATTERN_W-1:0];
      r_fill  <= '0;
      r_match <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (pat_load) begin
        r_pat <= pat_in;
      end else if (din_valid) begin
        r_hist <= w_new_hist;
      end
      r_fill  <= w_fill_d;
      r_armed <= (w_fill_d == FULL);
      r_match <= w_hit;
      r_cnt   <= w_cnt_d;
    end
  end

  assign match       = r_match;
  assign match_count = r_cnt;
  assign hist        = r_hist;
  assign armed       = r_armed;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model plus directed vectors.
// Mask test runs only when SEQDET_MASK_EN is defined.
module tb_seq_detector_param;

  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din;
  logic          din_valid;
  logic          overlap;
  logic          pat_load;
  logic [PW-1:0] pat_in;
  logic [PW-1:0] pat_mask_tb;
  logic          clr_count;

  logic          match;
  logic [15:0]   match_count;
  logic [PW-1:0] hist;
  logic          armed;
  logic          match2;
  logic [1:0]    count2;
  logic [PW-1:0] hist2;
  logic          armed2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detector_param u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
`ifdef SEQDET_MASK_EN
    .pat_mask    (pat_mask_tb),
`endif
    .clr_count   (clr_count),
    .match       (match),
    .match_count (match_count),
    .hist        (hist),
    .armed       (armed)
  );

  seq_detector_param #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
`ifdef SEQDET_MASK_EN
    .pat_mask    (pat_mask_tb),
`endif
    .clr_count   (clr_count),
    .match       (match2),
    .match_count (count2),
    .hist        (hist2),
    .armed       (armed2)
  );

  // Reference model: q holds bits since the last fill restart, hq the raw history.
  bit          q[$];
  bit          hq[$];
  bit [PW-1:0] m_pat;
  bit [PW-1:0] m_mask;
  bit          m_match;
  int          m_cnt;

  function automatic int hist_of();
    int h = 0;
    foreach (hq[i]) h = (h << 1) | int'(hq[i]);
    return h;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hit;
    hit = 1'b0;
    if (!rst_n) begin
      q.delete();
      hq.delete();
      m_pat   = 4'b0111;
      m_mask  = '0;
      m_match = 1'b0;
      m_cnt   = 0;
    end else begin
      if (pat_load) begin
        m_pat = pat_in;
`ifdef SEQDET_MASK_EN
        m_mask = pat_mask_tb;
`endif
        q.delete();
      end else if (din_valid) begin
        hq.push_back(din);
        if (hq.size() > PW) void'(hq.pop_front());
        q.push_back(din);
        if (q.size() > PW) void'(q.pop_front());
        if (q.size() == PW) begin
          hit = 1'b1;
          for (int i = 0; i < PW; i++)
            if (!m_mask[PW-1-i] && q[i] != m_pat[PW-1-i]) hit = 1'b0;
        end
        if (hit && !overlap) q.delete();
      end
      m_match = hit;
      if (clr_count) m_cnt = int'(hit);
      else m_cnt = m_cnt + int'(hit);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m.match", int'(match), int'(m_match));
    chk("m.count", int'(match_count), m_cnt);
    chk("m.hist", int'(hist), hist_of());
    chk("m.armed", int'(armed), int'(q.size() == PW));
    chk("m.match2", int'(match2), int'(m_match));
    chk("m.count2", int'(count2), (m_cnt > 3) ? 3 : m_cnt);
    chk("m.hist2", int'(hist2), hist_of());
    chk("m.armed2", int'(armed2), int'(q.size() == PW));
  end

  task automatic send(input bit d);
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #2;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load(input logic [PW-1:0] p, input logic [PW-1:0] m);
    pat_in      = p;
    pat_mask_tb = m;
    pat_load    = 1'b1;
    clr_count   = 1'b1;
    @(posedge clk);
    #2;
    pat_load  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n,
                           input logic [7:0] expm);
    for (int k = n - 1; k >= 0; k--) begin
      send(bits[k]);
      chk("seq.match", int'(match), int'(expm[k]));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    overlap     = 1'b1;
    pat_load    = 1'b0;
    pat_in      = '0;
    pat_mask_tb = '0;
    clr_count   = 1'b0;
    #3;
    chk("rst.hist", int'(hist), 0);
    chk("rst.count", int'(match_count), 0);
    chk("rst.armed", int'(armed), 0);
    chk("rst.match", int'(match), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Default pattern 0111
    send_bits(8'b0111, 4, 8'b0001);
    chk("t1.count", int'(match_count), 1);
    chk("t1.armed", int'(armed), 1);
    chk("t1.hist", int'(hist), 4'b0111);
    idle(1);
    chk("t1.pulse", int'(match), 0);

    // 1010 overlapping, then non-overlapping
    load(4'b1010, 4'b0000);
    chk("t2.armed0", int'(armed), 0);
    send_bits(8'b10101010, 8, 8'b00010101);
    chk("t2.count_ov", int'(match_count), 3);
    load(4'b1010, 4'b0000);
    overlap = 1'b0;
    send_bits(8'b10101010, 8, 8'b00010001);
    chk("t2.count_nov", int'(match_count), 2);
    chk("t2.armed_nov", int'(armed), 0);

    // Valid gap inside a sequence
    overlap = 1'b1;
    load(4'b0111, 4'b0000);
    send_bits(8'b011, 3, 8'b000);
    repeat (5) begin
      idle(1);
      chk("t3.gap", int'(match), 0);
    end
    send_bits(8'b1, 1, 8'b1);
    chk("t3.count", int'(match_count), 1);

    // Async reset mid-sequence
    send_bits(8'b011, 3, 8'b000);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    send_bits(8'b1, 1, 8'b0);
    chk("t4.hist", int'(hist), 4'b0001);
    chk("t4.count", int'(match_count), 0);
    chk("t4.armed", int'(armed), 0);

    // Saturation on the 2-bit counter, then clear coincident with hit
    repeat (5) send_bits(8'b0111, 4, 8'b0001);
    chk("t5.count16", int'(match_count), 5);
    chk("t5.count2", int'(count2), 3);
    send_bits(8'b011, 3, 8'b000);
    clr_count = 1'b1;
    send_bits(8'b1, 1, 8'b1);
    clr_count = 1'b0;
    chk("t5.clr16", int'(match_count), 1);
    chk("t5.clr2", int'(count2), 1);

`ifdef SEQDET_MASK_EN
    load(4'b0111, 4'b1000);
    send_bits(8'b1111, 4, 8'b0001);
    send_bits(8'b0101, 4, 8'b0000);
    chk("t6.count", int'(match_count), 1);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
